conv_sequencer: RTL and testbench
=================================

Name: conv_sequencer

Overview:
- Control FSM that sequences one convolution layer through the MAC datapath using the fields held in the Wishbone config register file.
- On a start request it walks kernels × output rows × output columns × kernel rows × kernel columns.
- Each beat it issues input-feature and kernel memory addresses plus MAC control strobes, then issues a result write per output pixel.
- Its done output feeds the config block's done status bit.

Parameters:
- AW, 12, width of in_addr, kern_addr and res_addr.
- PIPE, 3, cycles from the mac_last beat being accepted to the result being valid at the datapath output (PIPE ≥ 1).

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset; synchronous, active-low.
- start  in  1  level from config; a 0→1 edge requests a run.
- kern_cols  in  3  kernel side K; kernel is K×K.
- cols  in  8  input feature map width C; the map is square.
- kerns  in  3  number of kernels N.
- stride  in  8  convolution stride S.
- kern_addr_mode  in  1  0: kernels packed sequentially; 1: every kernel starts at address 0.
- result_cols  in  8  output map side R; the output map is R×R.
- dp_ready  in  1  datapath accepts a beat this cycle.
- in_addr  out  AW  input feature address.
- kern_addr  out  AW  kernel weight address.
- mac_en  out  1  beat valid.
- mac_clr  out  1  first tap of a window; accumulator loads instead of adds.
- mac_last  out  1  last tap of a window.
- res_addr  out  AW  result write address.
- res_we  out  1  result write strobe.
- busy  out  1  run in progress.
- done  out  1  run complete (status level).

Behaviour:
- Reset (wb_rst_i=0 at a clock edge): state IDLE; every output 0; all counters 0; start edge detector cleared. Reset mid-run aborts immediately and flushes the delay line, so no res_we fires afterwards.
- Start detection: rising edge of registered start. Edges while busy=1 are ignored.
- States:
  - IDLE: on a start edge, latch all config inputs, clear done, go to LOAD.
  - LOAD (1 cycle): busy=1. If K=0, N=0 or R=0, go to DONE with no beats issued; else go to RUN.
  - RUN: one beat per cycle with dp_ready=1. When dp_ready=0, hold all counters and addresses and deassert mac_en. After the final beat is accepted, go to DRAIN.
  - DRAIN: wait until the delay line is empty, then go to DONE.
  - DONE (1 cycle): done=1, busy=0, return to IDLE. done stays high until the next accepted start edge or reset.
- Loop order, outermost to innermost: k (0..N-1), orow, ocol (0..R-1), kr, kc (0..K-1). Total beats = N·R²·K².
- Beat outputs (combinational from counters; valid when mac_en=1):
  - in_addr = (orow·S + kr)·C + ocol·S + kc.
  - kern_addr = k·K² + kr·K + kc when mode=0; kr·K + kc when mode=1.
  - mac_clr = (kr=0 && kc=0); mac_last = (kr=K-1 && kc=K-1).
- Address arithmetic is computed at full width, then truncated modulo 2^AW. Implementation may be incremental (adders only) but must match the formulas exactly.
- Result write: an accepted mac_last beat pushes res_addr = k·R² + orow·R + ocol into a PIPE-deep shift line. res_we pulses exactly PIPE cycles later, with that res_addr on the same cycle.
  - The shift line advances every cycle regardless of dp_ready.
  - res_addr holds its last value when res_we=0.
- K=1: mac_clr and mac_last are both high on every beat.
- No bounds check on C versus R, K, S; addresses simply wrap.
- Config input changes during a run have no effect, because values are latched in IDLE.

Test Plan:
- C=4, K=2, S=1, R=3, N=1, mode=0, dp_ready=1 → 36 beats. First window in_addr 0,1,4,5 with mac_clr on beat 0 and mac_last on beat 3. Nine res_we pulses with res_addr 0..8, the first one PIPE cycles after beat 3. done rises the cycle after the DRAIN exit, busy falls.
- C=5, K=3, S=2, R=2, N=1 → window (orow 0, ocol 1) in_addr 2,3,4,7,8,9,12,13,14; window (1,0) starts at 10; 36 beats total.
- N=2, K=2, R=1, C=2: mode=0 → second kernel kern_addr 4,5,6,7 and res_addr 1. mode=1 → second kernel kern_addr 0,1,2,3.
- Toggle dp_ready 1,0,0,1 repeatedly in case 1 → addresses frozen while low and no mac_en. Same address/res_addr sequence as case 1; res_we count still 9.
- K=0 (or N=0 or R=0) with a start edge → no mac_en, no res_we; done=1 within 3 cycles. A second start edge while busy in case 1 is ignored: still 36 beats.
- Drive wb_rst_i=0 for one cycle at beat 10 of case 1 → all outputs 0 next cycle, no further res_we, done=0. A new start edge re-runs case 1 from beat 0.

Source files
------------

// File: rtl/conv_sequencer.sv
// Convolution layer sequencer: walks kernels x output pixels x kernel taps,
// drives MAC beat addresses/strobes and delayed result-write strobes.
module conv_sequencer #(
  parameter int unsigned AW   = 12,
  parameter int unsigned PIPE = 3
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          start,
  input  logic [2:0]    kern_cols,
  input  logic [7:0]    cols,
  input  logic [2:0]    kerns,
  input  logic [7:0]    stride,
  input  logic          kern_addr_mode,
  input  logic [7:0]    result_cols,
  input  logic          dp_ready,
  output logic [AW-1:0] in_addr,
  output logic [AW-1:0] kern_addr,
  output logic          mac_en,
  output logic          mac_clr,
  output logic          mac_last,
  output logic [AW-1:0] res_addr,
  output logic          res_we,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic       start_q1, start_q2, start_edge;
  logic [2:0] k_cfg, n_cfg;
  logic [7:0] c_cfg, s_cfg, r_cfg;
  logic       mode_cfg;

  logic [2:0] kidx, kr, kc;
  logic [7:0] orow, ocol;

  logic kc_wrap, kr_wrap, ocol_wrap, orow_wrap, kidx_wrap;
  logic accept, window_last, last_beat, cfg_empty, pipe_empty;

  logic [PIPE-1:0] pipe_v;
  logic [AW-1:0]   pipe_a [PIPE];
  logic [AW-1:0]   res_calc;
  logic            busy_q, done_q;

  assign start_edge = start_q1 & ~start_q2;

  assign kc_wrap   = (kc == k_cfg - 3'd1);
  assign kr_wrap   = (kr == k_cfg - 3'd1);
  assign ocol_wrap = (ocol == r_cfg - 8'd1);
  assign orow_wrap = (orow == r_cfg - 8'd1);
  assign kidx_wrap = (kidx == n_cfg - 3'd1);

  assign accept      = (state == RUN) && dp_ready;
  assign window_last = kc_wrap && kr_wrap;
  assign last_beat   = window_last && ocol_wrap && orow_wrap && kidx_wrap;
  assign cfg_empty   = (k_cfg == 3'd0) || (n_cfg == 3'd0) || (r_cfg == 8'd0);
  assign pipe_empty  = ~|pipe_v;

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) state <= IDLE;
    else           state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_edge) state_nxt = LOAD;
      LOAD:    state_nxt = cfg_empty ? DONE : RUN;
      RUN:     if (accept && last_beat) state_nxt = DRAIN;
      DRAIN:   if (pipe_empty) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Start edge detector and status flags
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      start_q1 <= 1'b0;
      start_q2 <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      start_q1 <= start;
      start_q2 <= start_q1;
      busy_q   <= (state_nxt == LOAD) || (state_nxt == RUN) || (state_nxt == DRAIN);
      if (state == IDLE && start_edge) done_q <= 1'b0;
      else if (state_nxt == DONE)      done_q <= 1'b1;
    end
  end

  // Config latch and loop counters; counters hold while the datapath stalls
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      k_cfg    <= 3'd0;
      n_cfg    <= 3'd0;
      c_cfg    <= 8'd0;
      s_cfg    <= 8'd0;
      r_cfg    <= 8'd0;
      mode_cfg <= 1'b0;
      kidx     <= 3'd0;
      kr       <= 3'd0;
      kc       <= 3'd0;
      orow     <= 8'd0;
      ocol     <= 8'd0;
    end else begin
      if (state == IDLE && start_edge) begin
        k_cfg    <= kern_cols;
        n_cfg    <= kerns;
        c_cfg    <= cols;
        s_cfg    <= stride;
        r_cfg    <= result_cols;
        mode_cfg <= kern_addr_mode;
      end
      if (state == LOAD) begin
        kidx <= 3'd0;
        kr   <= 3'd0;
        kc   <= 3'd0;
        orow <= 8'd0;
        ocol <= 8'd0;
      end else if (accept) begin
        kc <= kc_wrap ? 3'd0 : kc + 3'd1;
        if (kc_wrap) begin
          kr <= kr_wrap ? 3'd0 : kr + 3'd1;
          if (kr_wrap) begin
            ocol <= ocol_wrap ? 8'd0 : ocol + 8'd1;
            if (ocol_wrap) begin
              orow <= orow_wrap ? 8'd0 : orow + 8'd1;
              if (orow_wrap) kidx <= kidx_wrap ? 3'd0 : kidx + 3'd1;
            end
          end
        end
      end
    end
  end

  // Beat addresses at 32-bit width, truncated to AW
  assign in_addr = AW'((32'(orow) * 32'(s_cfg) + 32'(kr)) * 32'(c_cfg)
                       + 32'(ocol) * 32'(s_cfg) + 32'(kc));
  assign kern_addr = AW'((mode_cfg ? 32'd0 : 32'(kidx) * 32'(k_cfg) * 32'(k_cfg))
                         + 32'(kr) * 32'(k_cfg) + 32'(kc));
  assign res_calc = AW'(32'(kidx) * 32'(r_cfg) * 32'(r_cfg)
                        + 32'(orow) * 32'(r_cfg) + 32'(ocol));

  assign mac_en   = accept;
  assign mac_clr  = accept && (kr == 3'd0) && (kc == 3'd0);
  assign mac_last = accept && window_last;

  // Result delay line; address stages only load on valid so res_addr holds
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      pipe_v <= '0;
      for (int i = 0; i < PIPE; i++) pipe_a[i] <= '0;
    end else begin
      pipe_v[0] <= accept && window_last;
      if (accept && window_last) pipe_a[0] <= res_calc;
      for (int i = 1; i < PIPE; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) pipe_a[i] <= pipe_a[i-1];
      end
    end
  end

  assign res_we   = pipe_v[PIPE-1];
  assign res_addr = pipe_a[PIPE-1];
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: table of layer configs with hand-computed
// beat/result expectations, plus a mid-run reset sequence.
module tb_conv_sequencer;

  localparam int AW   = 12;
  localparam int PIPE = 3;

  logic          clk = 1'b0;
  logic          wb_rst_i;
  logic          start;
  logic [2:0]    kern_cols;
  logic [7:0]    cols;
  logic [2:0]    kerns;
  logic [7:0]    stride;
  logic          kern_addr_mode;
  logic [7:0]    result_cols;
  logic          dp_ready;
  logic [AW-1:0] in_addr, kern_addr, res_addr;
  logic          mac_en, mac_clr, mac_last, res_we, busy, done;

  always #5 clk = ~clk;

  conv_sequencer #(.AW(AW), .PIPE(PIPE)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .start(start),
    .kern_cols(kern_cols), .cols(cols), .kerns(kerns), .stride(stride),
    .kern_addr_mode(kern_addr_mode), .result_cols(result_cols),
    .dp_ready(dp_ready), .in_addr(in_addr), .kern_addr(kern_addr),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_last(mac_last),
    .res_addr(res_addr), .res_we(res_we), .busy(busy), .done(done)
  );

  typedef struct {
    int k, c, s, r, n, m;
    int dp, rs;
    int beats, res;
    int bi, bin, bkern;
  } vec_t;

  vec_t vecs[11];
  int total = 0;
  int bad   = 0;

  int b_in[$], b_kern[$], b_clr[$], b_last[$], b_cyc[$];
  int r_addr[$], r_cyc[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int n, done_cyc, en_bad, frz_bad, prev_in, seq_bad, res_bad, idx, ri;
    int ein, ekern, eclr, elast, eaddr, last_r;
    bit seen_busy, prev_hold;
    string tag;
    tag = $sformatf("v%0d", id);
    b_in.delete(); b_kern.delete(); b_clr.delete(); b_last.delete(); b_cyc.delete();
    r_addr.delete(); r_cyc.delete();
    kern_cols = 3'(v.k); cols = 8'(v.c); kerns = 3'(v.n);
    stride = 8'(v.s); kern_addr_mode = v.m[0]; result_cols = 8'(v.r);
    start = 1'b0; dp_ready = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b1;
    n = 0; done_cyc = -1; en_bad = 0; frz_bad = 0; prev_in = 0;
    seen_busy = 1'b0; prev_hold = 1'b0;
    while (done_cyc < 0 && n < 3000) begin
      @(negedge clk);
      n++;
      if (v.dp != 0) dp_ready = (n % 4 == 1) || (n % 4 == 0);
      if (v.rs != 0 && n == 10) start = 1'b0;
      if (v.rs != 0 && n == 12) start = 1'b1;
      #1;
      if (mac_en && !dp_ready) en_bad++;
      if (prev_hold && busy && int'(in_addr) != prev_in) frz_bad++;
      prev_hold = busy && !dp_ready;
      prev_in = int'(in_addr);
      if (mac_en) begin
        b_in.push_back(int'(in_addr)); b_kern.push_back(int'(kern_addr));
        b_clr.push_back(int'(mac_clr)); b_last.push_back(int'(mac_last));
        b_cyc.push_back(n);
      end
      if (res_we) begin
        r_addr.push_back(int'(res_addr)); r_cyc.push_back(n);
      end
      if (busy) seen_busy = 1'b1;
      if (seen_busy && done) done_cyc = n;
    end
    dp_ready = 1'b1;
    chk({tag, "_timeout"}, int'(done_cyc >= 0), 1);
    chk({tag, "_busy_at_done"}, int'(busy), 0);
    chk({tag, "_beats"}, b_in.size(), v.beats);
    chk({tag, "_res_count"}, r_addr.size(), v.res);
    if (v.bi >= 0 && v.bi < b_in.size()) begin
      chk({tag, "_in_addr_pick"}, b_in[v.bi], v.bin);
      chk({tag, "_kern_addr_pick"}, b_kern[v.bi], v.bkern);
    end else if (v.bi >= 0) begin
      chk({tag, "_pick_present"}, b_in.size(), v.bi + 1);
    end
    // Reference walk over the loop nest
    idx = 0; ri = 0; seq_bad = 0; res_bad = 0;
    for (int kk = 0; kk < v.n; kk++)
      for (int orw = 0; orw < v.r; orw++)
        for (int ocl = 0; ocl < v.r; ocl++)
          for (int kr = 0; kr < v.k; kr++)
            for (int kc = 0; kc < v.k; kc++) begin
              ein   = ((orw * v.s + kr) * v.c + ocl * v.s + kc) % (1 << AW);
              ekern = ((v.m != 0) ? 0 : kk * v.k * v.k) + kr * v.k + kc;
              eclr  = int'(kr == 0 && kc == 0);
              elast = int'(kr == v.k - 1 && kc == v.k - 1);
              if (idx < b_in.size()) begin
                if (b_in[idx] != ein || b_kern[idx] != ekern ||
                    b_clr[idx] != eclr || b_last[idx] != elast) seq_bad++;
              end
              if (elast != 0) begin
                eaddr = kk * v.r * v.r + orw * v.r + ocl;
                if (ri < r_addr.size() && idx < b_cyc.size()) begin
                  if (r_addr[ri] != eaddr || r_cyc[ri] != b_cyc[idx] + PIPE) res_bad++;
                end
                ri++;
              end
              idx++;
            end
    chk({tag, "_beat_seq_errs"}, seq_bad, 0);
    chk({tag, "_res_seq_errs"}, res_bad, 0);
    chk({tag, "_en_while_stalled"}, en_bad, 0);
    chk({tag, "_addr_not_frozen"}, frz_bad, 0);
    if (v.beats == 0) begin
      chk({tag, "_done_latency_ok"}, int'(done_cyc <= 3), 1);
    end else begin
      last_r = (r_cyc.size() > 0) ? r_cyc[r_cyc.size()-1] : -100;
      chk({tag, "_done_cycle"}, done_cyc, last_r + 2);
    end
    @(negedge clk); #1;
    chk({tag, "_done_hold"}, int'(done), 1);
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, int'(in_addr) + int'(kern_addr) + int'(res_addr) + int'(mac_en)
            + int'(mac_clr) + int'(mac_last) + int'(res_we) + int'(busy)
            + int'(done), 0);
  endtask

  initial begin
    int beats, rwe, n;
    vecs[0]  = '{k:2, c:4, s:1, r:3, n:1, m:0, dp:0, rs:0, beats:36, res:9, bi:3,  bin:5,  bkern:3};
    vecs[1]  = '{k:2, c:4, s:1, r:3, n:1, m:0, dp:0, rs:0, beats:36, res:9, bi:4,  bin:1,  bkern:0};
    vecs[2]  = '{k:3, c:5, s:2, r:2, n:1, m:0, dp:0, rs:0, beats:36, res:4, bi:9,  bin:2,  bkern:0};
    vecs[3]  = '{k:3, c:5, s:2, r:2, n:1, m:0, dp:0, rs:0, beats:36, res:4, bi:17, bin:14, bkern:8};
    vecs[4]  = '{k:3, c:5, s:2, r:2, n:1, m:0, dp:0, rs:0, beats:36, res:4, bi:18, bin:10, bkern:0};
    vecs[5]  = '{k:2, c:2, s:1, r:1, n:2, m:0, dp:0, rs:0, beats:8,  res:2, bi:7,  bin:3,  bkern:7};
    vecs[6]  = '{k:2, c:2, s:1, r:1, n:2, m:1, dp:0, rs:0, beats:8,  res:2, bi:7,  bin:3,  bkern:3};
    vecs[7]  = '{k:0, c:4, s:1, r:3, n:1, m:0, dp:0, rs:0, beats:0,  res:0, bi:-1, bin:0,  bkern:0};
    vecs[8]  = '{k:1, c:3, s:1, r:2, n:1, m:0, dp:0, rs:0, beats:4,  res:4, bi:3,  bin:4,  bkern:0};
    vecs[9]  = '{k:2, c:4, s:1, r:3, n:1, m:0, dp:1, rs:0, beats:36, res:9, bi:3,  bin:5,  bkern:3};
    vecs[10] = '{k:2, c:4, s:1, r:3, n:1, m:0, dp:0, rs:1, beats:36, res:9, bi:3,  bin:5,  bkern:3};

    wb_rst_i = 1'b0; start = 1'b0; dp_ready = 1'b1;
    kern_cols = 3'd2; cols = 8'd4; kerns = 3'd1; stride = 8'd1;
    kern_addr_mode = 1'b0; result_cols = 8'd3;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset_outputs");
    wb_rst_i = 1'b1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Zero-kernel and zero-output-size runs
    begin
      vec_t z;
      z = vecs[7]; z.k = 2; z.n = 0; run_vec(20, z);
      z = vecs[7]; z.k = 2; z.r = 0; run_vec(21, z);
    end

    // Reset at beat 10 of the basic layer
    kern_cols = 3'd2; cols = 8'd4; kerns = 3'd1; stride = 8'd1;
    kern_addr_mode = 1'b0; result_cols = 8'd3; dp_ready = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    beats = 0; n = 0;
    while (beats < 10 && n < 200) begin
      @(negedge clk); #1; n++;
      if (mac_en) beats++;
    end
    chk("rst_reached_beat10", beats, 10);
    wb_rst_i = 1'b0; start = 1'b0;
    @(negedge clk); #1;
    chk_all_zero("rst_midrun_outputs");
    wb_rst_i = 1'b1;
    rwe = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (res_we || mac_en || done) rwe++;
    end
    chk("rst_no_activity_after", rwe, 0);
    run_vec(30, vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
